// File: rtl/rsa_exp_ctrl_if.sv
// rsa_exp_ctrl_if: request/result bus plus multiplier handshake for rsa_exp_ctrl.
// slave  = controller view, master = requester / multiplier-side view.
interface rsa_exp_ctrl_if #(
  parameter int unsigned DW = 512,
  parameter int unsigned EW = 512,
  parameter int unsigned LW = 10
);
  logic          start;
  logic [DW-1:0] in_x;
  logic [DW-1:0] in_r;
  logic [DW-1:0] in_m;
  logic [EW-1:0] in_e;
  logic [LW-1:0] exp_len;
  logic [DW-1:0] result;
  logic          done;
  logic          busy;
  logic          mm_start;
  logic [DW-1:0] mm_a;
  logic [DW-1:0] mm_b;
  logic [DW-1:0] mm_m;
  logic [DW-1:0] mm_result;
  logic          mm_done;

  modport slave (
    input  start, in_x, in_r, in_m, in_e, exp_len, mm_result, mm_done,
    output result, done, busy, mm_start, mm_a, mm_b, mm_m
  );

  modport master (
    output start, in_x, in_r, in_m, in_e, exp_len, mm_result, mm_done,
    input  result, done, busy, mm_start, mm_a, mm_b, mm_m
  );
endinterface

// File: rtl/rsa_exp_ctrl.sv
// rsa_exp_ctrl: left-to-right square-and-multiply sequencer driving a
// Montgomery multiplier one operation at a time.
// Optional feature macro: RSA_EXP_FINAL_CONV_EN adds the final MM(A,1)
// step so result leaves the Montgomery domain.
// Outputs are registered from the next state, so each output is visible
// during the state cycle it belongs to.
module rsa_exp_ctrl #(
  parameter int unsigned DW = 512,
  parameter int unsigned EW = 512,
  parameter int unsigned LW = 10
) (
  input  logic           clk,
  input  logic           reset,
  rsa_exp_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE,
    NEXT,
    SQ_START,
    SQ_WAIT,
    MUL_START,
    MUL_WAIT,
`ifdef RSA_EXP_FINAL_CONV_EN
    CONV_START,
    CONV_WAIT,
`endif
    FIN
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] x_q, x_d;
  logic [DW-1:0] m_q, m_d;
  logic [EW-1:0] e_q, e_d;
  logic [LW-1:0] i_q, i_d;
  logic [DW-1:0] result_q, result_d;
  logic [DW-1:0] mm_a_q, mm_a_d;
  logic [DW-1:0] mm_b_q, mm_b_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          mm_start_q, mm_start_d;
  logic [EW-1:0] e_shift_c;
  logic          e_bit_c;

  // Exponent bit at the current index.
  always_comb begin
    e_shift_c = e_q >> i_q;
    e_bit_c   = e_shift_c[0];
  end

  // Next state, datapath updates and look-ahead outputs.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    x_d        = x_q;
    m_d        = m_q;
    e_d        = e_q;
    i_d        = i_q;
    result_d   = result_q;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    mm_start_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.in_r;
          x_d     = bus.in_x;
          m_d     = bus.in_m;
          e_d     = bus.in_e;
          i_d     = bus.exp_len;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (i_q == '0) begin
`ifdef RSA_EXP_FINAL_CONV_EN
          state_d = CONV_START;
`else
          state_d = FIN;
`endif
        end else begin
          i_d     = i_q - LW'(1);
          state_d = SQ_START;
        end
      end
      SQ_START:  state_d = SQ_WAIT;
      SQ_WAIT: begin
        if (bus.mm_done) begin
          a_d     = bus.mm_result;
          state_d = e_bit_c ? MUL_START : NEXT;
        end
      end
      MUL_START: state_d = MUL_WAIT;
      MUL_WAIT: begin
        if (bus.mm_done) begin
          a_d     = bus.mm_result;
          state_d = NEXT;
        end
      end
`ifdef RSA_EXP_FINAL_CONV_EN
      CONV_START: state_d = CONV_WAIT;
      CONV_WAIT: begin
        if (bus.mm_done) begin
          a_d     = bus.mm_result;
          state_d = FIN;
        end
      end
`endif
      FIN:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) && (state_d != FIN);

    case (state_d)
      SQ_START: begin
        mm_start_d = 1'b1;
        mm_a_d     = a_d;
        mm_b_d     = a_d;
      end
      MUL_START: begin
        mm_start_d = 1'b1;
        mm_a_d     = a_d;
        mm_b_d     = x_d;
      end
`ifdef RSA_EXP_FINAL_CONV_EN
      CONV_START: begin
        mm_start_d = 1'b1;
        mm_a_d     = a_d;
        mm_b_d     = DW'(1);
      end
`endif
      FIN: begin
        done_d   = 1'b1;
        result_d = a_d;
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      x_q        <= '0;
      m_q        <= '0;
      e_q        <= '0;
      i_q        <= '0;
      result_q   <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_start_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      x_q        <= x_d;
      m_q        <= m_d;
      e_q        <= e_d;
      i_q        <= i_d;
      result_q   <= result_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      mm_start_q <= mm_start_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.mm_start = mm_start_q;
  assign bus.mm_a     = mm_a_q;
  assign bus.mm_b     = mm_b_q;
  assign bus.mm_m     = m_q;

endmodule

// File: doc/rsa_exp_ctrl.md
# rsa_exp_ctrl

Controller for left-to-right binary square-and-multiply modular exponentiation. It sits directly upstream of the `montgomery` multiplier: it issues one multiplication at a time over that block's start/done handshake and consumes each result. Inputs arrive already in the Montgomery domain. The controller returns x^e mod M, converted back to the normal domain when configured to do so.

## Interface
- `DW`, 512, operand/modulus width; must match the multiplier.
- `EW`, 512, maximum exponent width.
- `LW`, 10, width of `exp_len`; must satisfy 2^LW > EW.

Ports. One clock `clk`; reset `reset` is synchronous and active-high.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  single-cycle request; honoured only in IDLE.
- `in_x`  in  DW  base in Montgomery form, x·R mod M.
- `in_r`  in  DW  R mod M, the Montgomery "one".
- `in_m`  in  DW  modulus, odd.
- `in_e`  in  EW  exponent.
- `exp_len`  in  LW  number of exponent bits processed; valid range 0..EW.
- `result`  out  DW  final value.
- `done`  out  1  one-cycle pulse when `result` becomes valid.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `mm_start`  out  1  one-cycle pulse to the multiplier.
- `mm_a`, `mm_b`, `mm_m`  out  DW  multiplier operands.
- `mm_result`  in  DW  multiplier output.
- `mm_done`  in  1  multiplier completion.

## Operation
- Registers:
  - A (accumulator), X, M, E.
  - Bit index `i` (LW bits).
  - Phase flag: square or multiply.
- Algorithm:
  - A = R.
  - For i = exp_len-1 down to 0: A = MM(A,A); then, if E[i], A = MM(A,X).
  - Then the conversion step, A = MM(A,1), when enabled (see Configuration).
  - `result` = A.
- States:
  - IDLE: on `start`, capture all inputs, set A=`in_r` and i=`exp_len`. Go to NEXT.
  - NEXT: if i==0, go to CONV_START (or to FIN when conversion is compiled out). Otherwise i=i-1 and go to SQ_START.
  - SQ_START: drive mm_a=A, mm_b=A, mm_start=1. Go to SQ_WAIT.
  - SQ_WAIT: on mm_done, set A=mm_result. If E[i], go to MUL_START; otherwise go to NEXT.
  - MUL_START: drive mm_a=A, mm_b=X, mm_start=1. Go to MUL_WAIT.
  - MUL_WAIT: on mm_done, set A=mm_result and go to NEXT.
  - CONV_START: drive mm_a=A, mm_b=1 (zero-extended), mm_start=1. Go to CONV_WAIT.
  - CONV_WAIT: on mm_done, set A=mm_result and go to FIN.
  - FIN: `result`=A, done=1 for one cycle. Go to IDLE.
- `mm_m` equals the captured M at all times after capture.
- `mm_a`/`mm_b` stay constant from the START cycle through the cycle in which mm_done is sampled.
- `start` while busy: ignored; captured registers are unchanged.
- mm_done outside a WAIT state: ignored.
- exp_len=0: no square or multiply steps. The result is the conversion of R, i.e. 1 (or R mod M when conversion is compiled out).
- exp_len>EW: undefined; the bench must not apply it.
- E bits at index ≥ exp_len: ignored.

## Timing
- Reset values: result=0, done=0, busy=0, mm_start=0, mm_a=0, mm_b=0, mm_m=0; state=IDLE.
- Reset mid-operation: on the next edge the block returns to IDLE with all outputs at their reset values. No mm_start is issued afterwards.
- Handshake:
  - mm_start is high for exactly one cycle, in a START state.
  - mm_done is sampled no earlier than the cycle after mm_start.
  - The multiplier's latency is arbitrary; the controller waits indefinitely.
- Per-operation cost: 1 START cycle + w cycles in WAIT, where w counts the mm_done cycle.
- Latency from the `start` edge to the `done` pulse = 1 (IDLE→NEXT) + (exp_len+1) NEXT cycles + Σ(1+w) over all operations + 1 (FIN).
- `result` holds its value until the next FIN. `busy` drops in the same cycle `done` pulses.

## Configuration
- `RSA_EXP_FINAL_CONV_EN`
  - Defined: CONV_START/CONV_WAIT are present, and `result` is in the normal domain.
  - Undefined: those states are removed, NEXT goes straight to FIN when i==0, and `result` stays in the Montgomery domain (A·R mod M).

## Test plan
- Reset behaviour: assert `reset` for 3 cycles. All outputs read 0, busy=0, and no mm_start appears.
- Operation sequence: exp_len=4, in_e=4'b1011, with a bench multiplier model of fixed latency 5.
  - Required sequence of (mm_a, mm_b) sources: S,M,S,S,M,S,M,C, i.e. 8 mm_start pulses.
  - done arrives exactly 1+5+8·6+1 = 55 cycles after `start`.
- Reference values with the real `montgomery` instance, DW=512: in_m=512'hfe93fee7…8fa2c393, in_x=x·R mod M, in_r=R mod M, e=65537 with exp_len=17. Required: `result` equals the Python reference pow(x,65537,M).
- Zero-length exponent: exp_len=0. Exactly one mm_start (conversion) is issued; result=1 with `RSA_EXP_FINAL_CONV_EN` defined, in_r without it.
- Ignored start: pulse `start` again during SQ_WAIT with different inputs. The operation completes with the original operands, and there is no extra done.
- Reset mid-operation: assert `reset` during MUL_WAIT. The next cycle shows IDLE with busy=0. A late mm_done is ignored, and a subsequent normal run gives the correct result.
